wash_billing_timer: RTL and testbench
=====================================

# wash_billing_timer

Parametrised wash-cycle sequencer with per-second billing and an N-digit multiplexed seven-segment countdown. It steps through fill, wash, rinse and spin phases of programmable length, decrements a signed balance by a fixed rate each second, and faults cleanly when credit runs out. It sits between the front-panel inputs and the LED/seven-segment outputs. It is the successor to the fixed 4-digit, two-state wash timer.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; one tick = CLK_HZ cycles (benches override to e.g. 10).
- DIGITS, 4, number of seven-segment digits (2..8).
- BAL_W, 12, balance width, signed two's complement.
- FILL_S / WASH_S / RINSE_S / SPIN_S, 5 / 20 / 10 / 8, phase durations in seconds (each 1..255).
- RATE, 1, balance units charged per active second.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- on  in  1  machine enable; low freezes tick counter and FSM (pause).
- start  in  1  level-sampled; starts cycle from IDLE.
- bal_load  in  1  loads bal_in into balance register; honoured only in IDLE.
- bal_in  in  BAL_W  signed credit value.
- bal  out  BAL_W  current signed balance.
- phase  out  3  encoded FSM state.
- st_light  out  8  one-hot phase lamp.
- led  out  8  segment pattern (active-low, bit7 = dp).
- ena  out  DIGITS  digit enables (active-low, one low at a time).
- done  out  1  one-cycle pulse on entry to DONE.
- fault  out  1  high while in FAULT.

## Operation
- States: IDLE(0) → FILL(1) → WASH(2) → RINSE(3) → SPIN(4) → DONE(5); FAULT(6) from any active phase.
- IDLE: display shows the total FILL_S+WASH_S+RINSE_S+SPIN_S in BCD. start=1 with on=1 and bal ≥ RATE → FILL, tick counter cleared.
- Active phase, on each tick: the phase seconds counter decrements; the BCD remaining display decrements by one with digit-wise borrow; bal ← bal − RATE.
- Phase exit: when the phase counter reaches 0 on a tick, go to the next phase and load its duration the same cycle.
- Credit check on each tick, before the decrement: if bal < RATE → FAULT. No charge is applied and the display is frozen.
- DONE: display shows all zeros. Return to IDLE when start=0.
- FAULT: exit only via bal_load in a following IDLE. Reaching IDLE requires start=0 and bal_load=1 together. That loads bal_in and reloads the display.
- on=0: the tick counter, FSM, counters and balance all hold. The scanner keeps running.
- Leading zeros are blanked (code n=blank), except the least significant digit.
- bal_load outside IDLE/FAULT is ignored. bal may be loaded negative; start is then refused.
- st_light: bit k set for state k (bit0 in IDLE), bit7 = fault lamp.

## Timing
- Reset values: bal=0, phase=IDLE, st_light=8'b0000_0001, done=0, fault=0, tick counter 0, display = total seconds, scanner on digit 0.
- Tick: a one-cycle pulse when the counter wraps from CLK_HZ−1 to 0. The first tick comes CLK_HZ cycles after the start is accepted.
- All state, balance and display updates are registered one cycle after the tick pulse. The outputs phase, bal and st_light follow the same cycle.
- done is asserted in the cycle phase becomes DONE.
- Scanner: each digit is held for 2^16 cycles (parameter SCAN_SH inside the sub-module). ena and led change in the same cycle.
- Requirement: total seconds < 10^DIGITS. Elaboration $error otherwise.

## Structure
- Package wash_pkg holds: the state enum (3 bits), the 4-bit BCD-to-segment function including the blank code 4'd11, and the st_light encoding.
- Sub-module seg_scan_n (parameter DIGITS) takes a packed 4·DIGITS BCD bus and drives ena/led.
- The top level holds: the tick divider, the FSM, the phase counter, the BCD down-counter and the balance arithmetic.
- Balance arithmetic: signed BAL_W compare and subtract. RATE is sign-extended to BAL_W.

## Test plan
- Normal cycle, CLK_HZ=10, bal_in=100, start → phases 1..5 at ticks 5, 25, 35, 43. done pulse at tick 43. bal=57. Display "  43" counts to "   0".
- Low credit, bal_in=7 → FAULT on tick 8 with bal=0 and phase=6. Display shows 36 and holds. fault=1 and st_light[7]=1.
- Pause: on=0 for 37 cycles mid-WASH → no change to bal, phase or display. The tick phase resumes exactly where it stopped.
- Refused start: bal_in=−3 → start is ignored and the FSM stays IDLE. bal_load during WASH → bal unchanged.
- Async reset mid-RINSE: rst low for 3 cycles, not clock-aligned → all outputs at reset values immediately. The scanner restarts at digit 0.
- Borrow and blanking, DIGITS=3, total=100 → after 1 tick the display shows " 99". ena cycles through 3 one-cold patterns.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash billing timer: FSM state encoding,
// seven-segment decode (active-low, dp off) and phase lamp encoding.
package wash_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4,
      S_DONE  = 3'd5,
      S_FAULT = 3'd6
   } state_t;

   localparam logic [3:0] BCD_BLANK = 4'd11;

   // Segment order {dp,g,f,e,d,c,b,a}, all active-low.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // FAULT lights its own state bit plus the dedicated fault lamp on bit7.
   function automatic logic [7:0] st_lamp(input state_t s);
      if (s == S_FAULT) return 8'hC0;
      return 8'h01 << s;
   endfunction

endpackage

// File: rtl/wash_billing_timer_if.sv
// Front-panel / display bundle of the wash billing timer.
interface wash_billing_timer_if #(
   parameter int DIGITS = 4,
   parameter int BAL_W  = 12
);
   logic                    on_i;
   logic                    start_i;
   logic                    bal_load_i;
   logic signed [BAL_W-1:0] bal_in_i;
   logic signed [BAL_W-1:0] bal_o;
   logic [2:0]              phase_o;
   logic [7:0]              st_light_o;
   logic [7:0]              led_o;
   logic [DIGITS-1:0]       ena_o;
   logic                    done_o;
   logic                    fault_o;

   modport master (
      output on_i, start_i, bal_load_i, bal_in_i,
      input  bal_o, phase_o, st_light_o, led_o, ena_o, done_o, fault_o
   );

   modport slave (
      input  on_i, start_i, bal_load_i, bal_in_i,
      output bal_o, phase_o, st_light_o, led_o, ena_o, done_o, fault_o
   );
endinterface

// File: rtl/seg_scan_n.sv
// N-digit multiplexed seven-segment scanner; each digit held 2^SCAN_SH cycles.
module seg_scan_n import wash_pkg::*; #(
   parameter int DIGITS  = 4,
   parameter int SCAN_SH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DIGITS-1:0][3:0] bcd_i,
   output logic [DIGITS-1:0]      ena_o,
   output logic [7:0]             led_o
);
   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [SCAN_SH-1:0] div_q;
   logic [SW-1:0]      sel_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         sel_q <= '0;
      end else begin
         div_q <= div_q + SCAN_SH'(1);
         if (&div_q) sel_q <= (sel_q == SW'(DIGITS - 1)) ? '0 : sel_q + SW'(1);
      end
   end

   // ena and led both derive from sel_q, so they switch in the same cycle.
   assign ena_o = ~(DIGITS'(1) << sel_q);
   assign led_o = seg7(bcd_i[sel_q]);
endmodule

// File: rtl/wash_billing_timer.sv
// Wash-cycle sequencer: tick divider, phase FSM, per-second billing and a
// BCD countdown of remaining seconds fed to the digit scanner.
module wash_billing_timer import wash_pkg::*; #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int DIGITS  = 4,
   parameter int BAL_W   = 12,
   parameter int FILL_S  = 5,
   parameter int WASH_S  = 20,
   parameter int RINSE_S = 10,
   parameter int SPIN_S  = 8,
   parameter int RATE    = 1,
   parameter int SCAN_SH = 16
) (
   input logic                 clk,
   input logic                 rst,
   wash_billing_timer_if.slave bus
);
   localparam int TOTAL = FILL_S + WASH_S + RINSE_S + SPIN_S;
   localparam int CW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic signed [BAL_W-1:0] RATE_S = BAL_W'(RATE);

   function automatic logic [DIGITS-1:0][3:0] to_bcd(input int v);
      logic [DIGITS-1:0][3:0] r;
      int t;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[i] = 4'(t % 10);
         t    = t / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] phase_len(input state_t s);
      case (s)
         S_WASH:  return 8'(WASH_S);
         S_RINSE: return 8'(RINSE_S);
         S_SPIN:  return 8'(SPIN_S);
         default: return 8'(FILL_S);
      endcase
   endfunction

   localparam logic [DIGITS-1:0][3:0] TOTAL_BCD = to_bcd(TOTAL);

   if (TOTAL >= 10 ** DIGITS) begin : g_total_chk
      $error("wash_billing_timer: total seconds do not fit in DIGITS");
   end
   if (DIGITS < 2 || DIGITS > 8) begin : g_digits_chk
      $error("wash_billing_timer: DIGITS must be 2..8");
   end

   state_t                  state_q;
   logic signed [BAL_W-1:0] bal_q;
   logic [7:0]              sec_q;
   logic [DIGITS-1:0][3:0]  bcd_q, bcd_dec, disp;
   logic [CW-1:0]           tcnt_q;
   logic                    done_q, active, tick, borrow, lead;
   state_t                  nxt;

   assign active = (state_q >= S_FILL) && (state_q <= S_SPIN);
   assign tick   = bus.on_i && active && (tcnt_q == CW'(CLK_HZ - 1));
   assign nxt    = state_t'(state_q + 3'd1);

   // Divider only runs in active phases, so each cycle starts a fresh second.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             tcnt_q <= '0;
      else if (!active)     tcnt_q <= '0;
      else if (bus.on_i)    tcnt_q <= tick ? '0 : tcnt_q + CW'(1);
   end

   always_comb begin
      bcd_dec = bcd_q;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (bcd_q[i] == 4'd0) bcd_dec[i] = 4'd9;
            else begin
               bcd_dec[i] = bcd_q[i] - 4'd1;
               borrow     = 1'b0;
            end
         end
      end
   end

   // Blank leading zeros; the least significant digit always shows.
   always_comb begin
      disp = bcd_q;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (lead && bcd_q[i] == 4'd0) disp[i] = BCD_BLANK;
         else                          lead    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         bal_q   <= '0;
         sec_q   <= '0;
         bcd_q   <= TOTAL_BCD;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.on_i) begin
            case (state_q)
               S_IDLE: begin
                  if (bus.bal_load_i) bal_q <= bus.bal_in_i;
                  else if (bus.start_i && bal_q >= RATE_S) begin
                     state_q <= S_FILL;
                     sec_q   <= phase_len(S_FILL);
                  end
               end
               S_DONE: begin
                  if (!bus.start_i) begin
                     state_q <= S_IDLE;
                     bcd_q   <= TOTAL_BCD;
                  end
               end
               S_FAULT: begin
                  if (!bus.start_i && bus.bal_load_i) begin
                     state_q <= S_IDLE;
                     bal_q   <= bus.bal_in_i;
                     bcd_q   <= TOTAL_BCD;
                  end
               end
               default: begin
                  // Credit is checked before charging; a fault freezes everything.
                  if (tick) begin
                     if (bal_q < RATE_S) state_q <= S_FAULT;
                     else begin
                        bal_q <= bal_q - RATE_S;
                        bcd_q <= bcd_dec;
                        if (sec_q == 8'd1) begin
                           if (state_q == S_SPIN) begin
                              state_q <= S_DONE;
                              done_q  <= 1'b1;
                              bcd_q   <= '0;
                           end else begin
                              state_q <= nxt;
                              sec_q   <= phase_len(nxt);
                           end
                        end else sec_q <= sec_q - 8'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.bal_o      = bal_q;
   assign bus.phase_o    = state_q;
   assign bus.st_light_o = st_lamp(state_q);
   assign bus.done_o     = done_q;
   assign bus.fault_o    = (state_q == S_FAULT);

   seg_scan_n #(.DIGITS(DIGITS), .SCAN_SH(SCAN_SH)) u_scan (
      .clk   (clk),
      .rst   (rst),
      .bcd_i (disp),
      .ena_o (bus.ena_o),
      .led_o (bus.led_o)
   );
endmodule

// File: tb/tb_wash_billing_timer.sv
// Randomized directed bench for wash_billing_timer against a seconds-based model.
module tb_wash_billing_timer;
   localparam int TOT = 43;

   logic clk, rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int   DUR [4] = '{5, 20, 10, 8};

   wash_billing_timer_if #(.DIGITS(4), .BAL_W(12)) ba ();
   wash_billing_timer_if #(.DIGITS(3), .BAL_W(12)) bb ();

   wash_billing_timer #(.CLK_HZ(10), .SCAN_SH(1)) u_a (.clk(clk), .rst(rst), .bus(ba));
   wash_billing_timer #(.CLK_HZ(10), .DIGITS(3), .FILL_S(25), .WASH_S(25), .RINSE_S(25),
                        .SPIN_S(25), .SCAN_SH(1)) u_b (.clk(clk), .rst(rst), .bus(bb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected phase after t seconds of a full-credit run.
   function automatic int exp_phase(input int t);
      int c = 0;
      for (int p = 0; p < 4; p++) begin
         c += DUR[p];
         if (t < c) return p + 1;
      end
      return 5;
   endfunction

   function automatic logic [7:0] lamp(input int p);
      return (p == 6) ? 8'hC0 : 8'(1 << p);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Checks the currently scanned digit of a displayed value v.
   task automatic chk_disp(input string tag, input logic [7:0] en, input logic [7:0] led, input int v);
      int k = 0;
      int p10 = 1;
      logic [7:0] e;
      chk({tag, "_cold"}, 32'($countones(en)), 32'd7);
      for (int i = 0; i < 8; i++) if (!en[i]) k = i;
      for (int i = 0; i < k; i++) p10 *= 10;
      e = (k > 0 && v < p10) ? 8'hFF : SEG[(v / p10) % 10];
      chk({tag, "_led"}, 32'(led), 32'(e));
   endtask

   task automatic chk_a(input string tag, input int ph, input int b, input int v);
      chk({tag, "_phase"}, 32'(ba.phase_o), 32'(ph));
      chk({tag, "_bal"}, 32'(ba.bal_o), 32'(b));
      chk({tag, "_lamp"}, 32'(ba.st_light_o), 32'(lamp(ph)));
      chk({tag, "_fault"}, 32'(ba.fault_o), 32'(ph == 6));
      chk_disp(tag, {4'hF, ba.ena_o}, ba.led_o, v);
   endtask

   task automatic load_a(input int v);
      ba.bal_load_i = 1'b1;
      ba.bal_in_i   = 12'(v);
      cyc(1);
      ba.bal_load_i = 1'b0;
      chk("load_bal", 32'(ba.bal_o), 32'(v));
   endtask

   task automatic run(input int bal0, input int ptick, input int rtick);
      int b, ft, x, nb;
      load_a(bal0);
      ba.start_i = 1'b1;
      cyc(1);
      chk("start_phase", 32'(ba.phase_o), 32'd1);
      b  = bal0;
      ft = bal0 + 1;
      for (int t = 1; t <= TOT; t++) begin
         if (t == ptick) begin
            x = $urandom_range(1, 8);
            cyc(x);
            ba.on_i = 1'b0;
            for (int i = 0; i < 37; i++) begin
               cyc(1);
               chk_a("pause", exp_phase(t - 1), b, TOT - t + 1);
            end
            ba.on_i = 1'b1;
            cyc(9 - x);
            chk_a("resume", exp_phase(t - 1), b, TOT - t + 1);
            cyc(1);
         end else cyc(10);
         if (t == rtick) begin
            #2 rst = 1'b0;
            ba.start_i = 1'b0;
            #1;
            chk_a("arst", 0, 0, TOT);
            chk("arst_done", 32'(ba.done_o), 32'd0);
            chk("arst_ena", 32'(ba.ena_o), 32'hE);
            #27 rst = 1'b1;
            cyc(1);
            return;
         end
         if (t == ft) begin
            chk_a("fault", 6, b, TOT - t + 1);
            ba.bal_load_i = 1'b1;
            ba.bal_in_i   = 12'($urandom_range(0, 500));
            cyc(4);
            chk_a("fault_hold", 6, b, TOT - t + 1);
            nb = $urandom_range(0, 500);
            ba.start_i  = 1'b0;
            ba.bal_in_i = 12'(nb);
            cyc(1);
            ba.bal_load_i = 1'b0;
            chk_a("fault_exit", 0, nb, TOT);
            return;
         end
         b -= 1;
         chk_a("tick", exp_phase(t), b, TOT - t);
         chk("done", 32'(ba.done_o), 32'(t == TOT));
         if (t == 10) begin
            ba.bal_load_i = 1'b1;
            ba.bal_in_i   = 12'($urandom_range(0, 2000));
         end else ba.bal_load_i = 1'b0;
      end
      cyc(3);
      chk_a("done_hold", 5, b, 0);
      chk("done_pulse", 32'(ba.done_o), 32'd0);
      ba.start_i = 1'b0;
      cyc(1);
      chk_a("done_exit", 0, b, TOT);
   endtask

   initial begin
      logic [2:0] seen;
      rst = 1'b1;
      ba.on_i = 1'b1; ba.start_i = 1'b0; ba.bal_load_i = 1'b0; ba.bal_in_i = '0;
      bb.on_i = 1'b1; bb.start_i = 1'b0; bb.bal_load_i = 1'b0; bb.bal_in_i = '0;
      #2 rst = 1'b0;
      #8;
      chk_a("reset", 0, 0, TOT);
      chk("reset_done", 32'(ba.done_o), 32'd0);
      chk("reset_ena", 32'(ba.ena_o), 32'hE);
      chk_disp("reset_b", {5'h1F, bb.ena_o}, bb.led_o, 100);
      #13 rst = 1'b1;
      cyc(1);

      // Negative credit refuses start.
      load_a(-3);
      ba.start_i = 1'b1;
      cyc(15);
      chk_a("refused", 0, -3, TOT);
      ba.start_i = 1'b0;
      cyc(1);

      run(100, $urandom_range(6, 24), 0);
      run(7, 0, 0);
      run($urandom_range(1, 42), 0, 0);
      run($urandom_range(43, 1500), $urandom_range(6, 24), $urandom_range(26, 34));

      // Three-digit instance: 100 -> " 99" with multi-digit borrow and blanking.
      bb.bal_load_i = 1'b1;
      bb.bal_in_i   = 12'd5;
      cyc(1);
      bb.bal_load_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk_disp("b_idle", {5'h1F, bb.ena_o}, bb.led_o, 100);
      end
      bb.start_i = 1'b1;
      cyc(11);
      seen = '0;
      for (int i = 0; i < 6; i++) begin
         chk_disp("b_tick", {5'h1F, bb.ena_o}, bb.led_o, 99);
         seen |= ~bb.ena_o;
         cyc(1);
      end
      chk("b_scan", 32'(seen), 32'h7);
      chk("b_bal", 32'(bb.bal_o), 32'd4);
      bb.start_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
